// File: rtl/ant_nav_fsm_pkg.sv
// Shared types for the wall-following ant controller: state codes and the
// Moore motor-command decode used by the top level.
package ant_nav_fsm_pkg;

    typedef enum logic [1:0] {
        ST_LOST = 2'd0,
        ST_A    = 2'd1,
        ST_B    = 2'd2,
        ST_E    = 2'd3
    } ant_state_e;

    // Returns {fw, tleft, tright}; "away" is left when following a right-hand wall.
    function automatic logic [2:0] motor_cmd(input ant_state_e st, input logic mode);
        logic [2:0] cmd;
        case (st)
            ST_LOST: cmd = 3'b100;
            ST_A:    cmd = {1'b1, mode, ~mode};
            ST_B:    cmd = {1'b1, ~mode, mode};
            ST_E:    cmd = {1'b0, mode, ~mode};
            default: cmd = 3'b100;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/ant_step_timer.sv
// Step-gated clear/increment counter that flags when it has reached LIMIT-1.
// It never counts past LIMIT-1, so the flag stays up until the next clear.
module ant_step_timer #(
    parameter int unsigned LIMIT = 1,
    parameter int unsigned W     = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins over increment, increment stops at LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (en && clr) begin
            cnt_d = {W{1'b0}};
        end else if (en && inc && (cnt_q != LAST)) begin
            cnt_d = cnt_q + W'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/ant_nav_fsm.sv
// Wall-following navigation FSM for the ant robot: selectable wall side,
// step-enable, turn hold when blocked, wall-lost timeout and step odometer.
module ant_nav_fsm
    import ant_nav_fsm_pkg::*;
#(
    parameter int unsigned LOST_TIMEOUT = 8,
    parameter int unsigned TURN_HOLD    = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             step,
    input  logic             LAntenna,
    input  logic             RAntenna,
    input  logic             follow_right,
    output logic             FW,
    output logic             TLeft,
    output logic             TRight,
    output logic [1:0]       state_out,
    output logic             lost_flag,
    output logic [CNT_W-1:0] step_count
);

    localparam int unsigned MISS_W = $clog2(LOST_TIMEOUT + 1);
    localparam int unsigned HOLD_W = $clog2(TURN_HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    ant_state_e       state_q, state_d;
    logic             mode_q, mode_d;
    logic             lost_flag_q, lost_flag_d;
    logic             fw_q, fw_d;
    logic             tleft_q, tleft_d;
    logic             tright_q, tright_d;
    logic [CNT_W-1:0] step_count_q, step_count_d;

    logic wall_s, far_s;
    logic miss_exp_s, hold_exp_s;
    logic miss_clr_s, miss_inc_s, hold_clr_s, hold_inc_s;

    assign wall_s = mode_q ? RAntenna : LAntenna;
    assign far_s  = mode_q ? LAntenna : RAntenna;

    // Counters clear on entry to their state and count only on self-loops.
    assign miss_clr_s = (state_d == ST_B) && (state_q != ST_B);
    assign miss_inc_s = (state_d == ST_B) && (state_q == ST_B);
    assign hold_clr_s = (state_d == ST_E) && (state_q != ST_E);
    assign hold_inc_s = (state_d == ST_E) && (state_q == ST_E);

    ant_step_timer #(.LIMIT(LOST_TIMEOUT), .W(MISS_W)) u_miss_timer (
        .clk     (CLK),
        .reset   (reset),
        .en      (step),
        .clr     (miss_clr_s),
        .inc     (miss_inc_s),
        .expired (miss_exp_s)
    );

    ant_step_timer #(.LIMIT(TURN_HOLD), .W(HOLD_W)) u_hold_timer (
        .clk     (CLK),
        .reset   (reset),
        .en      (step),
        .clr     (hold_clr_s),
        .inc     (hold_inc_s),
        .expired (hold_exp_s)
    );

    // State, mode latch, registered outputs and odometer.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= ST_LOST;
            mode_q       <= follow_right;
            lost_flag_q  <= 1'b0;
            fw_q         <= 1'b1;
            tleft_q      <= 1'b0;
            tright_q     <= 1'b0;
            step_count_q <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            lost_flag_q  <= lost_flag_d;
            fw_q         <= fw_d;
            tleft_q      <= tleft_d;
            tright_q     <= tright_d;
            step_count_q <= step_count_d;
        end
    end

    // Next state, mode latch and timeout pulse; everything holds without step.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        lost_flag_d = 1'b0;
        if (step) begin
            if (state_q == ST_LOST) begin
                mode_d = follow_right;
            end else begin
                mode_d = mode_q;
            end
            case (state_q)
                ST_LOST: begin
                    if (far_s)       state_d = ST_E;
                    else if (wall_s) state_d = ST_A;
                    else             state_d = ST_LOST;
                end
                ST_A: begin
                    if (far_s)       state_d = ST_E;
                    else if (wall_s) state_d = ST_A;
                    else             state_d = ST_B;
                end
                ST_B: begin
                    if (far_s) begin
                        state_d = ST_E;
                    end else if (wall_s) begin
                        state_d = ST_A;
                    end else if (miss_exp_s) begin
                        state_d     = ST_LOST;
                        lost_flag_d = 1'b1;
                    end else begin
                        state_d = ST_B;
                    end
                end
                ST_E: begin
                    if (!hold_exp_s)  state_d = ST_E;
                    else if (far_s)   state_d = ST_E;
                    else if (wall_s)  state_d = ST_A;
                    else              state_d = ST_B;
                end
                default: state_d = ST_LOST;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Motor commands are decoded from the upcoming state so they register in step with it.
    always_comb begin
        {fw_d, tleft_d, tright_d} = motor_cmd(state_d, mode_d);
        step_count_d = step_count_q;
        if (step && fw_q && (step_count_q != CNT_MAX)) begin
            step_count_d = step_count_q + CNT_W'(1'b1);
        end else begin
            step_count_d = step_count_q;
        end
    end

    assign FW         = fw_q;
    assign TLeft      = tleft_q;
    assign TRight     = tright_q;
    assign state_out  = state_q;
    assign lost_flag  = lost_flag_q;
    assign step_count = step_count_q;

endmodule

// File: doc/ant_nav_fsm.md
Name: ant_nav_fsm

Overview:
Parametrised wall-following navigation controller for the ant robot. It is the next generation of the two-antenna ant FSM, and adds the following:
- selectable wall side (left- or right-hand following);
- a step-enable tick;
- a minimum turn-hold time when blocked;
- a wall-lost timeout that returns the ant to the searching state;
- a saturating forward-step odometer.

It sits between the antenna inputs and the motor-command outputs on the DE1 top level.

Parameters:
LOST_TIMEOUT, 8, consecutive no-contact steps in state B before declaring the wall lost (legal: >=1)
TURN_HOLD, 2, minimum steps spent in state E once entered (legal: >=1; 1 = no hold)
CNT_W, 16, width of the forward-step odometer

Ports:
CLK  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-high reset
step  in  1  advance enable; FSM, counters and mode latch update only on cycles with step=1
LAntenna  in  1  left antenna contact
RAntenna  in  1  right antenna contact
follow_right  in  1  wall side select (1 = wall on right); latched only while in LOST
FW  out  1  drive forward
TLeft  out  1  turn left
TRight  out  1  turn right
state_out  out  2  current state code (debug/LEDs)
lost_flag  out  1  one-cycle pulse on B->LOST timeout
step_count  out  CNT_W  forward-step odometer, saturating

Behaviour:
- One clock (CLK). Reset is synchronous and active-high.
- Reset applies on posedge CLK with reset=1 and overrides step. After reset:
  - state=LOST; mode_q=follow_right; miss_cnt=0; hold_cnt=0; step_count=0; lost_flag=0.
  - Outputs therefore read FW=1, TLeft=0, TRight=0, state_out=LOST.
- States: LOST=0, A=1 (wall-side contact), B=2 (no contact, seeking wall), E=3 (far-side contact/blocked).
- Wall-side antenna w = mode_q ? RAntenna : LAntenna. Far-side antenna f = the other one.
- Transitions apply only on step=1. With step=0 all registers hold.
  - LOST: f=1 -> E; w=1,f=0 -> A; 00 -> LOST. mode_q <= follow_right on every step taken while in LOST.
  - A: f=1 -> E; w only -> A; 00 -> B.
  - B: f=1 -> E; w only -> A. On 00:
    - if miss_cnt == LOST_TIMEOUT-1 -> LOST, and lost_flag=1 for that cycle;
    - otherwise stay in B and increment miss_cnt.
  - E: if hold_cnt < TURN_HOLD-1, stay in E and increment hold_cnt, regardless of antennae. Otherwise use the A table (f=1 -> E, w only -> A, 00 -> B).
- Counter clears:
  - miss_cnt clears to 0 on every transition into B from another state.
  - hold_cnt clears to 0 on every transition into E from another state. A self-loop E->E with the hold expired does not re-clear it.
- B timeout: B->LOST happens on exactly the LOST_TIMEOUT-th consecutive 00 step spent in B.
- Outputs are Moore: a pure function of registered state and mode_q, with no input-to-output combinational path. "away" = left if mode_q=1, else right; "toward" = the opposite.
  - LOST: FW=1, no turn.
  - A: FW=1, turn away.
  - B: FW=1, turn toward.
  - E: FW=0, turn away.
  - TLeft and TRight are never both 1.
- step_count increments on each step=1 cycle where the current FW=1, and saturates at all-ones (no wrap).
- lost_flag is registered and asserts in the cycle after the timeout step edge. It is 0 otherwise, including during reset.
- Reset mid-operation (any state, any counter value) returns to the reset values above on that edge.
- Illegal state codes cannot occur with a 2-bit code. The default branch still forces LOST.
- Mode changes on follow_right outside LOST are ignored until the FSM next re-enters LOST.

Decomposition:
- Shared header ant_defs.vh holds:
  - state codes LOST/A/B/E;
  - localparam widths: MISS_W = $clog2(LOST_TIMEOUT+1), HOLD_W = $clog2(TURN_HOLD+1).
- One natural sub-module: ant_step_timer. It is a clear/increment/expire counter parametrised by limit. It is instantiated twice, for miss_cnt and hold_cnt.
- The saturating odometer stays inline.

Test Plan:
1. Reset, follow_right=1, defaults; step pulses with RAntenna=1 only -> LOST->A; outputs FW=1, TLeft=1, TRight=0, matching the original right-hand behaviour.
2. follow_right=0, mirrored stimulus LAntenna=1 only -> A with TRight=1. Then change follow_right to 1 while in A -> outputs unchanged until LOST is re-entered.
3. LOST_TIMEOUT=4: from A apply 00 steps -> B for steps 1-4, LOST after step 5 (4th step in B), lost_flag high exactly one cycle. RAntenna=1 on step 4 instead -> A, no flag.
4. TURN_HOLD=3: LAntenna=1 (mode right) -> E, FW=0, TLeft=1. Then 00 steps -> remains E for 2 more steps, goes to B on the 3rd.
5. step=0 for 10 cycles with toggling antennae -> state, counters and outputs frozen. CNT_W=4: 20 forward steps -> step_count saturates at 15.
6. Assert reset for one cycle while in E with hold_cnt=1 and step_count=9 -> next cycle LOST, step_count=0, FW=1, no turn.
